// File: rtl/mem_bridge.sv
// Memory access unit for the multicycle CPU. It turns a controller access
// request into a req/ack bus transaction and loads IR or MDR with the read
// word. It returns a one-cycle completion pulse. Misaligned addresses and bus
// timeouts raise sticky error flags.
module mem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_valid,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic [31:0] pc,
  input  logic [31:0] aluout,
  input  logic [31:0] wdata,
  input  logic        err_clr,
  output logic        acc_done,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value during the last REQ cycle allowed before aborting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              kind, kind_nx;
  logic              acc_done_nx;
  logic              mem_req_nx, mem_we_nx;
  logic [31:0]       mem_addr_nx, mem_wdata_nx;
  logic [31:0]       ir_nx, mdr_nx;
  logic              misaligned_nx, bus_err_nx;
  logic              mis_set, berr_set;
  logic [31:0]       addr_sel;

  // Next-state, bus outputs, data registers and error-flag updates.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    kind_nx      = kind;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    ir_nx        = ir;
    mdr_nx       = mdr;
    mis_set      = 1'b0;
    berr_set     = 1'b0;
    addr_sel     = IorD ? aluout : pc;

    case (state)
      IDLE: begin
        if (acc_valid) begin
          kind_nx = IorD;
          if (addr_sel[1:0] != 2'b00) begin
            // A misaligned access never reaches the bus.
            mis_set  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx     = REQ;
            mem_req_nx   = 1'b1;
            mem_we_nx    = IorD & MemWrite;
            mem_addr_nx  = addr_sel;
            mem_wdata_nx = wdata;
            cnt_nx       = '0;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          // An ack wins over a timeout expiring in the same cycle.
          if (!mem_we) begin
            if (kind) mdr_nx = mem_rdata;
            else      ir_nx  = mem_rdata;
          end
          mem_req_nx = 1'b0;
          mem_we_nx  = 1'b0;
          state_nx   = DONE;
        end else if (cnt == CNT_LAST) begin
          berr_set   = 1'b1;
          mem_req_nx = 1'b0;
          mem_we_nx  = 1'b0;
          state_nx   = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
        mem_we_nx  = 1'b0;
      end
    endcase

    acc_done_nx   = (state_nx == DONE);
    // A new error that sets on the same edge as a clear wins.
    misaligned_nx = (misaligned & ~err_clr) | mis_set;
    bus_err_nx    = (bus_err & ~err_clr) | berr_set;
  end

  // State, counter and all registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      kind       <= 1'b0;
      acc_done   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ir         <= '0;
      mdr        <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      kind       <= kind_nx;
      acc_done   <= acc_done_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      ir         <= ir_nx;
      mdr        <= mdr_nx;
      misaligned <= misaligned_nx;
      bus_err    <= bus_err_nx;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with TIMEOUT=4 and hand-computed expectations.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_valid = 1'b0;
  logic        IorD = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] aluout = '0;
  logic [31:0] wdata = '0;
  logic        err_clr = 1'b0;
  logic        acc_done;
  logic [31:0] ir, mdr;
  logic        misaligned, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_bridge #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_valid  (acc_valid),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .pc         (pc),
    .aluout     (aluout),
    .wdata      (wdata),
    .err_clr    (err_clr),
    .acc_done   (acc_done),
    .ir         (ir),
    .mdr        (mdr),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_acc_done", 32'(acc_done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir", ir, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
    rst = 1'b1;
    step();

    // Fetch, zero-wait
    IorD = 1'b0; MemWrite = 1'b0; pc = 32'h0000_3000; acc_valid = 1'b1;
    step();
    check("f_req", 32'(mem_req), 32'd1);
    check("f_addr", mem_addr, 32'h0000_3000);
    check("f_we", 32'(mem_we), 32'd0);
    check("f_done_c1", 32'(acc_done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    step();
    check("f_done_c2", 32'(acc_done), 32'd1);
    check("f_ir", ir, 32'h2008_0005);
    check("f_mdr", mdr, 32'h0);
    check("f_req_drop", 32'(mem_req), 32'd0);
    acc_valid = 1'b0; mem_ack = 1'b0;
    step();
    check("f_done_c3", 32'(acc_done), 32'd0);

    // Load with 3 wait cycles
    IorD = 1'b1; MemWrite = 1'b0; aluout = 32'h0000_1004; acc_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ld_req_%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("ld_done_%0d", i), 32'(acc_done), 32'd0);
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    check("ld_done", 32'(acc_done), 32'd1);
    check("ld_mdr", mdr, 32'hDEAD_BEEF);
    check("ld_ir", ir, 32'h2008_0005);
    check("ld_berr", 32'(bus_err), 32'd0);
    acc_valid = 1'b0; mem_ack = 1'b0;
    step();
    check("ld_done_off", 32'(acc_done), 32'd0);

    // Store; inputs change during REQ
    IorD = 1'b1; MemWrite = 1'b1; aluout = 32'h0000_2000; wdata = 32'h1234_5678;
    acc_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    pc = 32'h0000_5555; wdata = 32'hAAAA_AAAA; aluout = 32'h0000_7000;
    check("st_we", 32'(mem_we), 32'd1);
    check("st_wdata", mem_wdata, 32'h1234_5678);
    check("st_addr", mem_addr, 32'h0000_2000);
    step();
    check("st_wdata_hold", mem_wdata, 32'h1234_5678);
    check("st_addr_hold", mem_addr, 32'h0000_2000);
    check("st_req_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    step();
    check("st_done", 32'(acc_done), 32'd1);
    check("st_ir", ir, 32'h2008_0005);
    check("st_mdr", mdr, 32'hDEAD_BEEF);
    acc_valid = 1'b0; mem_ack = 1'b0; MemWrite = 1'b0;
    step();

    // Misaligned load, clear, then clear colliding with a new misaligned access
    IorD = 1'b1; aluout = 32'h0000_1002; acc_valid = 1'b1;
    step();
    check("mis_done", 32'(acc_done), 32'd1);
    check("mis_flag", 32'(misaligned), 32'd1);
    check("mis_req", 32'(mem_req), 32'd0);
    check("mis_mdr", mdr, 32'hDEAD_BEEF);
    acc_valid = 1'b0;
    step();
    check("mis_sticky", 32'(misaligned), 32'd1);
    err_clr = 1'b1;
    step();
    check("mis_clr", 32'(misaligned), 32'd0);
    acc_valid = 1'b1;
    step();
    check("mis_set_wins", 32'(misaligned), 32'd1);
    acc_valid = 1'b0; err_clr = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Timeout, no ack
    IorD = 1'b1; aluout = 32'h0000_1008; acc_valid = 1'b1; mem_ack = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("to_berr_%0d", i), 32'(bus_err), 32'd0);
      step();
    end
    check("to_req_drop", 32'(mem_req), 32'd0);
    check("to_done", 32'(acc_done), 32'd1);
    check("to_berr", 32'(bus_err), 32'd1);
    check("to_mdr", mdr, 32'hDEAD_BEEF);
    acc_valid = 1'b0; err_clr = 1'b1;
    step();
    check("to_berr_clr", 32'(bus_err), 32'd0);
    err_clr = 1'b0;

    // Ack on the final timeout cycle wins
    aluout = 32'h0000_100C; acc_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    check("tw_done", 32'(acc_done), 32'd1);
    check("tw_berr", 32'(bus_err), 32'd0);
    check("tw_mdr", mdr, 32'hCAFE_F00D);
    acc_valid = 1'b0; mem_ack = 1'b0;
    step();

    // Leave misaligned set, then reset in the 2nd REQ cycle of a fetch
    aluout = 32'h0000_0001; acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
    step();
    IorD = 1'b0; pc = 32'h0000_4000; acc_valid = 1'b1;
    step();
    step();
    check("rs_pre_req", 32'(mem_req), 32'd1);
    check("rs_pre_mis", 32'(misaligned), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rs_req", 32'(mem_req), 32'd0);
    check("rs_done", 32'(acc_done), 32'd0);
    check("rs_flags", {30'd0, misaligned, bus_err}, 32'd0);
    check("rs_ir", ir, 32'h0);
    check("rs_mdr", mdr, 32'h0);
    acc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_ack = 1'b0;
    check("rs_late_ir", ir, 32'h0);
    check("rs_late_mdr", mdr, 32'h0);
    check("rs_late_done", 32'(acc_done), 32'd0);
    step();
    check("rs_late_req", 32'(mem_req), 32'd0);
    check("rs_late_done2", 32'(acc_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
